// File: rtl/hs_fifo_pkt_policer.sv
// Packet policer in front of an async FIFO write port: drops errored or runt
// packets, truncates overlong ones, and counts ok/dropped packets.
module hs_fifo_pkt_policer #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 256,
    parameter int MIN_BEATS  = 1,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  src_clk,
    input  logic                  src_rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  s_err,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  m_wlast,
    output logic                  m_wdrop,
    output logic [STAT_WIDTH-1:0] pkt_ok_cnt,
    output logic [STAT_WIDTH-1:0] pkt_drop_cnt,
    output logic                  overlong
);
    // state      | meaning
    // ST_PASS    | beats load the output register, packet checks active
    // ST_DISCARD | remainder of a truncated packet is swallowed until s_last

    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic {ST_PASS, ST_DISCARD} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] cnt_inc;
    logic          sticky;
    logic          load;
    logic          trunc;
    logic          pkt_bad;

    always_ff @(posedge src_clk) begin
        if (src_rst) state <= ST_PASS;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        load      = 1'b0;
        trunc     = 1'b0;
        cnt_inc   = beat_cnt + CW'(1);
        case (state)
            ST_PASS: begin
                s_ready = !src_rst && (!m_wvalid || m_wready);
                if (s_valid && s_ready) begin
                    load = 1'b1;
                    if (!s_last && cnt_inc == CW'(MAX_BEATS)) begin
                        trunc     = 1'b1;
                        state_nxt = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                s_ready = !src_rst;
                if (s_valid && s_ready && s_last) state_nxt = ST_PASS;
            end
            default: state_nxt = ST_PASS;
        endcase
    end

    // cnt_inc counts the current beat, so a runt is detected on its last beat
    assign pkt_bad = sticky || s_err || (cnt_inc < CW'(MIN_BEATS));

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            m_wvalid     <= 1'b0;
            m_wdata      <= '0;
            m_wlast      <= 1'b0;
            m_wdrop      <= 1'b0;
            beat_cnt     <= '0;
            sticky       <= 1'b0;
            overlong     <= 1'b0;
            pkt_ok_cnt   <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            overlong <= trunc;
            if (load) begin
                m_wvalid <= 1'b1;
                m_wdata  <= s_data;
                m_wlast  <= s_last || trunc;
                m_wdrop  <= trunc || (s_last && pkt_bad);
                if (s_last || trunc) begin
                    beat_cnt <= '0;
                    sticky   <= 1'b0;
                end else begin
                    beat_cnt <= cnt_inc;
                    sticky   <= sticky || s_err;
                end
            end else if (m_wready) begin
                m_wvalid <= 1'b0;
            end

            if (m_wvalid && m_wready && m_wlast) begin
                if (m_wdrop) begin
                    if (!(&pkt_drop_cnt)) pkt_drop_cnt <= pkt_drop_cnt + STAT_WIDTH'(1);
                end else begin
                    if (!(&pkt_ok_cnt)) pkt_ok_cnt <= pkt_ok_cnt + STAT_WIDTH'(1);
                end
            end
        end
    end
endmodule
